// File: rtl/adc_sample_spi_master.sv
// adc_sample_spi_master
//   Sends one ADC sample as a two-byte SPI frame (mode 0, MSB first) under a
//   single spi_ss low period, and captures the byte returned on spi_miso.
//     byte0 = sample[7:0]
//     byte1 = {sample_channel, 2'b00, sample[9:8]}
//   Frame timing, in units of CLK_DIV clk cycles:
//     SETUP 1, byte0 16, GAP 1, byte1 16, HOLD 1  -> spi_ss low for 35.
//
// Parameters
//   CLK_DIV        clk cycles per SCK half-period (2..255)
// Ports
//   clk, rst_n     clock; asynchronous active-low reset
//   sample         10-bit sample value
//   sample_channel 4-bit source channel
//   new_sample     one-cycle send request (taken when busy is low)
//   busy           a request would not be accepted now
//   frame_done     one-cycle pulse when spi_ss returns high at the end of a frame
//   spi_ss/sck/mosi/miso  SPI master pins
//   rx_data        last byte received on spi_miso
//   new_rx_data    one-cycle pulse when rx_data updates (twice per frame)
// Build option
//   SAMPLE_BUF_EN  adds a one-entry pending buffer so a request arriving
//                  during a frame is held and sent right after it.
module adc_sample_spi_master #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] sample,
   input  logic [3:0] sample_channel,
   input  logic       new_sample,
   output logic       busy,
   output logic       frame_done,
   output logic       spi_ss,
   output logic       spi_sck,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic [7:0] rx_data,
   output logic       new_rx_data
);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD, SS_IDLE} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   // Without a pending frame SS_IDLE is one cycle short: the IDLE cycle in
   // which the next request is taken supplies the last cycle of spi_ss high.
   localparam logic [7:0] SSI_LAST = 8'(CLK_DIV - 2);

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   logic [2:0]  bit_cnt;
   logic        byte_sel;
   logic [15:0] tx_sr;
   logic [7:0]  rx_sr;
   logic        cnt_last, start, rise, fall, bit_end, done;
   logic        req, ssi_end, ssi_go;
   logic [9:0]  ld_sample;
   logic [3:0]  ld_chan;

   assign cnt_last = (cnt == DIV_LAST);
   assign spi_mosi = tx_sr[15];

`ifdef SAMPLE_BUF_EN
   logic       buf_vld;
   logic [9:0] buf_sample;
   logic [3:0] buf_chan;

   assign busy      = buf_vld;
   assign req       = new_sample | buf_vld;
   assign ld_sample = buf_vld ? buf_sample : sample;
   assign ld_chan   = buf_vld ? buf_chan   : sample_channel;
   // Going straight from SS_IDLE to SETUP, SS_IDLE must cover all CLK_DIV
   // high cycles by itself.
   assign ssi_end   = (cnt == (buf_vld ? DIV_LAST : SSI_LAST));
   assign ssi_go    = buf_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_vld    <= 1'b0;
         buf_sample <= '0;
         buf_chan   <= '0;
      end else if (start && buf_vld) begin
         buf_vld <= 1'b0;
      end else if (new_sample && !buf_vld && state != IDLE) begin
         buf_vld    <= 1'b1;
         buf_sample <= sample;
         buf_chan   <= sample_channel;
      end
   end
`else
   assign busy      = (state != IDLE);
   assign req       = new_sample;
   assign ld_sample = sample;
   assign ld_chan   = sample_channel;
   assign ssi_end   = (cnt == SSI_LAST);
   assign ssi_go    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      rise      = 1'b0;
      fall      = 1'b0;
      bit_end   = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:
            if (req) begin
               state_nxt = SETUP;
               start     = 1'b1;
            end
         SETUP, GAP:
            if (cnt_last) begin
               state_nxt = SHIFT;
               rise      = 1'b1;
            end
         SHIFT:
            if (cnt_last) begin
               if (spi_sck) begin
                  fall = 1'b1;
               end else begin
                  bit_end = 1'b1;
                  if (bit_cnt != 3'd7) rise = 1'b1;
                  else                 state_nxt = byte_sel ? HOLD : GAP;
               end
            end
         HOLD:
            if (cnt_last) begin
               state_nxt = SS_IDLE;
               done      = 1'b1;
            end
         SS_IDLE:
            if (ssi_end) begin
               if (ssi_go) begin
                  state_nxt = SETUP;
                  start     = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         default: state_nxt = IDLE;
      endcase
   end

   // Phase counter: restarts on every state change and every SCK half-period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                          cnt <= '0;
      else if (state_nxt != state || cnt_last || state == IDLE) cnt <= '0;
      else                                                 cnt <= cnt + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spi_ss      <= 1'b1;
         spi_sck     <= 1'b0;
         tx_sr       <= '0;
         rx_sr       <= '0;
         bit_cnt     <= '0;
         byte_sel    <= 1'b0;
         rx_data     <= '0;
         new_rx_data <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= done;
         spi_ss     <= (state_nxt == IDLE) || (state_nxt == SS_IDLE);
         // First low cycle after the 8th falling SCK of a byte.
         new_rx_data <= (state == SHIFT) && !spi_sck && (cnt == 8'd0) && (bit_cnt == 3'd7);
         if ((state == SHIFT) && !spi_sck && (cnt == 8'd0) && (bit_cnt == 3'd7))
            rx_data <= rx_sr;
         if (start) begin
            tx_sr    <= {ld_sample[7:0], ld_chan, 2'b00, ld_sample[9:8]};
            bit_cnt  <= '0;
            byte_sel <= 1'b0;
         end
         if (rise) begin
            spi_sck <= 1'b1;
            rx_sr   <= {rx_sr[6:0], spi_miso};
         end
         if (fall) begin
            spi_sck <= 1'b0;
            tx_sr   <= {tx_sr[14:0], 1'b0};
         end
         if (bit_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) byte_sel <= ~byte_sel;
         end
      end
   end

endmodule

// File: tb/tb_adc_sample_spi_master.sv
// Directed bench for adc_sample_spi_master at CLK_DIV=2.
module tb_adc_sample_spi_master;
   localparam int C = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] sample = '0;
   logic [3:0] sample_channel = '0;
   logic       new_sample = 1'b0;
   logic       busy, frame_done, spi_ss, spi_sck, spi_mosi, spi_miso;
   logic [7:0] rx_data;
   logic       new_rx_data;

   int n_tests = 0;
   int n_fail  = 0;

   // monitor / slave model state
   logic [1:0]  miso_mode = 2'd1;   // 0: tied 0, 1: tied 1, 2: slave pattern
   logic [15:0] slave_tx = '0;
   logic [7:0]  acc = '0;
   int          bit_n = 0, low_cnt = 0, high_cnt = 0, done_cnt = 0;
   logic        sck_d = 1'b0, ss_d = 1'b1;
   logic [7:0]  mosi_q[$];
   logic [7:0]  rx_q[$];
   int          low_q[$];
   int          high_q[$];

   assign spi_miso = (miso_mode == 2'd2) ? slave_tx[15] : miso_mode[0];

   adc_sample_spi_master #(.CLK_DIV(C)) dut (
      .clk(clk), .rst_n(rst_n), .sample(sample), .sample_channel(sample_channel),
      .new_sample(new_sample), .busy(busy), .frame_done(frame_done),
      .spi_ss(spi_ss), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .rx_data(rx_data), .new_rx_data(new_rx_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst_n) begin
         bit_n = 0; acc = '0; low_cnt = 0;
      end else begin
         if (spi_sck && !sck_d) begin
            acc = {acc[6:0], spi_mosi};
            bit_n++;
            if (bit_n == 8) begin mosi_q.push_back(acc); bit_n = 0; end
         end
         if (!spi_sck && sck_d) slave_tx = {slave_tx[14:0], 1'b0};
         if (!spi_ss && ss_d) begin
            slave_tx = 16'hC35A;
            high_q.push_back(high_cnt);
            high_cnt = 0;
         end
         if (spi_ss && !ss_d) begin low_q.push_back(low_cnt); low_cnt = 0; end
         if (!spi_ss) low_cnt++; else high_cnt++;
         if (frame_done) done_cnt++;
         if (new_rx_data) rx_q.push_back(rx_data);
      end
      sck_d = spi_sck;
      ss_d  = spi_ss;
   end

   function automatic logic [47:0] mosi_bytes(input int base, input int n);
      logic [47:0] r = '0;
      for (int i = 0; i < n; i++)
         r = {r[39:0], (base + i < mosi_q.size()) ? mosi_q[base + i] : 8'hxx};
      return r;
   endfunction

   function automatic logic [15:0] rx_bytes(input int base);
      logic [15:0] r = '0;
      for (int i = 0; i < 2; i++)
         r = {r[7:0], (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx};
      return r;
   endfunction

   task automatic send(input logic [9:0] s, input logic [3:0] ch);
      int t = 0;
      @(posedge clk); #1;
      while (busy && t < 300) begin @(posedge clk); #1; t++; end
      if (t >= 300) begin
         n_tests++; n_fail++;
         $display("FAIL send_timeout: busy stayed 1, required 0 within 300 cycles");
      end
      sample = s; sample_channel = ch; new_sample = 1'b1;
      @(posedge clk); #1;
      new_sample = 1'b0;
      sample = ~s; sample_channel = ~ch;   // later changes must not reach the frame
   endtask

   task automatic wait_done(input int target, input int bound);
      int t = 0;
      while (done_cnt < target && t < bound) begin @(posedge clk); t++; end
      if (done_cnt < target) begin
         n_tests++; n_fail++;
         $display("FAIL done_timeout: frame_done count %0d, required %0d", done_cnt, target);
      end
      repeat (C + 6) @(posedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({spi_ss, spi_sck, spi_mosi, busy, frame_done, new_rx_data, rx_data} !== {6'b100000, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_state: got ss%b sck%b mosi%b busy%b done%b nrx%b rx%h, required 1 0 0 0 0 0 00",
                  spi_ss, spi_sck, spi_mosi, busy, frame_done, new_rx_data, rx_data);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int mb = mosi_q.size(), rb = rx_q.size(), lb = low_q.size(), db = done_cnt;
      miso_mode = 2'd1;
      send(10'h2A5, 4'h3);
      wait_done(db + 1, 200);
      n_tests++;
      if (mosi_bytes(mb, 2) !== 48'hA532) begin
         n_fail++; $display("FAIL basic_mosi: got %h, required a532", mosi_bytes(mb, 2));
      end
      n_tests++;
      if (low_q.size() != lb + 1 || low_q[lb] != 35 * C) begin
         n_fail++; $display("FAIL basic_ss_low: got %0d entries, required one of %0d cycles", low_q.size() - lb, 35 * C);
      end
      n_tests++;
      if (done_cnt - db != 1) begin
         n_fail++; $display("FAIL basic_frame_done: got %0d pulses, required 1", done_cnt - db);
      end
      n_tests++;
      if (rx_q.size() != rb + 2 || rx_bytes(rb) !== 16'hFFFF) begin
         n_fail++; $display("FAIL basic_rx_ones: got %0d pulses data %h, required 2 pulses ffff", rx_q.size() - rb, rx_bytes(rb));
      end
   endtask

   task automatic test_rx_pattern();
      int mb = mosi_q.size(), rb = rx_q.size(), db = done_cnt;
      miso_mode = 2'd2;
      send(10'h000, 4'h0);
      wait_done(db + 1, 200);
      n_tests++;
      if (rx_q.size() != rb + 2 || rx_bytes(rb) !== 16'hC35A) begin
         n_fail++; $display("FAIL rx_pattern: got %0d pulses data %h, required 2 pulses c35a", rx_q.size() - rb, rx_bytes(rb));
      end
      n_tests++;
      if (mosi_bytes(mb, 2) !== 48'h0000) begin
         n_fail++; $display("FAIL rx_pattern_mosi: got %h, required 0000", mosi_bytes(mb, 2));
      end
      miso_mode = 2'd1;
   endtask

   task automatic test_reset_mid_frame();
      int mb = mosi_q.size(), t = 0, db;
      send(10'h155, 4'h5);
      while (!(mosi_q.size() == mb + 1 && bit_n == 3) && t < 200) begin @(negedge clk); t++; end
      n_tests++;
      if (t >= 200) begin n_fail++; $display("FAIL abort_reach: byte1 bit 3 not reached, required within 200 cycles"); end
      db = done_cnt;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({spi_ss, spi_sck, spi_mosi, busy, new_rx_data, rx_data} !== {5'b10000, 8'h00}) begin
         n_fail++;
         $display("FAIL abort_state: got ss%b sck%b mosi%b busy%b nrx%b rx%h, required 1 0 0 0 0 00",
                  spi_ss, spi_sck, spi_mosi, busy, new_rx_data, rx_data);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      n_tests++;
      if (done_cnt != db) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses, required 0", done_cnt - db); end
      mb = mosi_q.size();
      db = done_cnt;
      send(10'h1C4, 4'h9);
      wait_done(db + 1, 200);
      n_tests++;
      if (mosi_bytes(mb, 2) !== 48'hC491) begin
         n_fail++; $display("FAIL abort_recover: got %h, required c491", mosi_bytes(mb, 2));
      end
   endtask

`ifndef SAMPLE_BUF_EN
   task automatic test_back_to_back();
      int mb = mosi_q.size(), hb = high_q.size(), db = done_cnt, t = 0;
      @(posedge clk); #1;
      while (busy && t < 300) begin @(posedge clk); #1; t++; end
      // A new request is taken every 36*C cycles: 35*C low, C high.
      for (int k = 0; k <= 144; k++) begin
         sample = 10'(k + 'h300);
         sample_channel = 4'(k) ^ 4'hA;
         new_sample = 1'b1;
         @(posedge clk); #1;
      end
      new_sample = 1'b0;
      wait_done(db + 3, 300);
      n_tests++;
      if (mosi_bytes(mb, 6) !== 48'h00A3_4823_90A3) begin
         n_fail++; $display("FAIL b2b_mosi: got %h, required 00a3482390a3", mosi_bytes(mb, 6));
      end
      n_tests++;
      if (high_q.size() != hb + 3 || high_q[hb + 1] != C || high_q[hb + 2] != C) begin
         n_fail++; $display("FAIL b2b_ss_high: got %0d frames, gaps %0d %0d, required 3 frames gaps %0d",
                            high_q.size() - hb, (high_q.size() > hb + 1) ? high_q[hb + 1] : -1,
                            (high_q.size() > hb + 2) ? high_q[hb + 2] : -1, C);
      end
      n_tests++;
      if (done_cnt - db != 3) begin n_fail++; $display("FAIL b2b_done: got %0d pulses, required 3", done_cnt - db); end
   endtask
`else
   task automatic test_buffer();
      int mb = mosi_q.size(), hb = high_q.size(), db = done_cnt;
      send(10'h001, 4'h0);
      repeat (20) @(posedge clk);
      #1;
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL buf_empty_busy: got %b, required 0", busy); end
      sample = 10'h3FF; sample_channel = 4'hF; new_sample = 1'b1;
      @(posedge clk); #1;
      new_sample = 1'b0; sample = '0; sample_channel = '0;
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL buf_full_busy: got %b, required 1", busy); end
      repeat (5) @(posedge clk);
      #1;
      sample = 10'h155; sample_channel = 4'h5; new_sample = 1'b1;
      @(posedge clk); #1;
      new_sample = 1'b0;
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL buf_drop_busy: got %b, required 1", busy); end
      wait_done(db + 2, 400);
      repeat (100) @(posedge clk);
      n_tests++;
      if (mosi_q.size() != mb + 4 || mosi_bytes(mb, 4) !== 48'h0100_FFF3) begin
         n_fail++; $display("FAIL buf_mosi: got %0d bytes %h, required 4 bytes 0100fff3", mosi_q.size() - mb, mosi_bytes(mb, 4));
      end
      n_tests++;
      if (done_cnt - db != 2) begin n_fail++; $display("FAIL buf_done: got %0d pulses, required 2", done_cnt - db); end
      n_tests++;
      if (high_q.size() != hb + 2 || high_q[hb + 1] != C) begin
         n_fail++; $display("FAIL buf_ss_high: got %0d frames, required 2 with gap %0d", high_q.size() - hb, C);
      end
      #1;
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL buf_drained_busy: got %b, required 0", busy); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_rx_pattern();
      test_reset_mid_frame();
`ifndef SAMPLE_BUF_EN
      test_back_to_back();
`else
      test_buffer();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required finish within 2 ms");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/adc_sample_spi_master.md
ADC_SAMPLE_SPI_MASTER -- requirements
Module: adc_sample_spi_master

Interface
REQ-001 SHALL have parameter: CLK_DIV, default 4; clk cycles per SCK half-period, legal range 2..255.
REQ-002 SHALL have port: clk  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: sample  in  10  ADC sample value.
REQ-005 SHALL have port: sample_channel  in  4  channel the sample came from.
REQ-006 SHALL have port: new_sample  in  1  one-cycle request to send sample/sample_channel.
REQ-007 SHALL have port: busy  out  1  high when a new_sample would not be accepted.
REQ-008 SHALL have port: frame_done  out  1  one-cycle pulse when a frame ends.
REQ-009 SHALL have ports: spi_ss out 1, spi_sck out 1, spi_mosi out 1, spi_miso in 1; SPI master, mode 0, MSB first.
REQ-010 SHALL have ports: rx_data out 8, new_rx_data out 1; byte shifted in on spi_miso, with one-cycle valid pulse.

Function
REQ-011 Frame SHALL be two bytes under one spi_ss low period: byte0 = sample[7:0]; byte1 = {sample_channel[3:0], 2'b00, sample[9:8]}.
REQ-012 Accept: new_sample high while busy low captures sample and sample_channel into a frame register in that cycle; later input changes do not affect the frame.
REQ-013 States: IDLE, SETUP, SHIFT, GAP, HOLD, SS_IDLE.
REQ-014 IDLE: spi_ss=1, spi_sck=0. On accept -> SETUP; spi_ss goes low and spi_mosi carries byte0 bit7 in the next cycle.
REQ-015 SETUP: CLK_DIV cycles -> SHIFT.
REQ-016 SHIFT: per bit, spi_sck high CLK_DIV cycles then low CLK_DIV cycles; spi_mosi changes only on the cycle spi_sck falls; spi_miso sampled on the cycle spi_sck rises.
REQ-017 After 8th bit of byte0 -> GAP: spi_sck low, spi_ss low, CLK_DIV cycles, spi_mosi = byte1 bit7 -> SHIFT for byte1.
REQ-018 After 8th bit of byte1 -> HOLD: CLK_DIV cycles, then spi_ss=1 and frame_done pulses one cycle -> SS_IDLE.
REQ-019 spi_ss SHALL be low for exactly 35*CLK_DIV clk cycles per frame.
REQ-020 SS_IDLE: spi_ss high for CLK_DIV cycles -> IDLE; a new frame never starts with less than CLK_DIV cycles of spi_ss high.
REQ-021 rx_data SHALL update and new_rx_data SHALL pulse one cycle after the 8th bit falling sck of each byte (two pulses per frame).
REQ-022 new_sample while busy high SHALL be ignored, except as REQ-027.
REQ-023 Without SAMPLE_BUF_EN: busy = (state != IDLE).

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, spi_ss=1, spi_sck=0, spi_mosi=0, busy=0, frame_done=0, new_rx_data=0, rx_data=8'h00, all counters 0.
REQ-025 Reset mid-frame SHALL abort the frame with no frame_done; release of rst_n synchronous to clk; first accept possible the cycle after release.

Configuration
REQ-026 Macro SAMPLE_BUF_EN SHALL compile in a one-entry pending buffer.
REQ-027 With SAMPLE_BUF_EN: new_sample while a frame is active and buffer empty is stored; busy = buffer full; on leaving SS_IDLE a stored sample starts SETUP immediately (no IDLE cycle) and the buffer empties; new_sample while buffer full is dropped.
REQ-028 Without SAMPLE_BUF_EN: no buffer logic exists; behaviour per REQ-022/023.

Verification
REQ-029 CLK_DIV=2, sample=10'h2A5, channel=4'h3 -> MOSI bytes 0xA5, 0x32; spi_ss low 70 cycles; one frame_done.
REQ-030 spi_miso tied 1, any frame -> two new_rx_data pulses, rx_data=8'hFF each.
REQ-031 new_sample asserted every cycle, no SAMPLE_BUF_EN -> frames back-to-back with exactly CLK_DIV cycles spi_ss high between; only accepted values sent.
REQ-032 SAMPLE_BUF_EN: send 10'h001/ch 0, then 10'h3FF/ch 15 and 10'h155 mid-frame -> bytes 0x01,0x00,0xFF,0xF3; 10'h155 dropped; busy high from second request until buffer drains.
REQ-033 rst_n low during byte1 bit 3 -> spi_ss=1, spi_sck=0 same cycle; no frame_done; next new_sample produces a full correct frame.
REQ-034 Sample inputs changed the cycle after accept -> transmitted bytes match values at accept.
